pc_stack: RTL and testbench
===========================

// Module: pc_stack
// PURPOSE
//  Parametrised program counter with a hardware return-address stack for nested subroutines.
//  Sits in the fetch stage and drives the instruction-memory address.
//  Supports sequential increment, absolute load, PC-relative call (signed offset) and return.
//  Stack overflow/underflow are detected and flagged; the PC and stack are protected.
// PARAMETERS
//  ADDR_W    11   PC / address width in bits
//  OFFSET_W  10   call offset width; two's complement, sign-extended to ADDR_W (OFFSET_W <= ADDR_W)
//  DEPTH     4    return-stack entries (>= 1)
//  RESET_PC  0    PC value after reset
// PORTS
//  clk        in   1                     clock, all state changes on rising edge
//  rst        in   1                     asynchronous, active-high reset
//  en         in   1                     step qualifier; no state change when 0
//  load       in   1                     absolute jump: pc <= addr
//  jsr        in   1                     call: push pc+1, pc <= pc + sext(addr[OFFSET_W-1:0])
//  ret        in   1                     return: pc <= popped address
//  addr       in   ADDR_W                jump target / call offset (low OFFSET_W bits)
//  err_clr    in   1                     clears sticky error flags
//  pc         out  ADDR_W                current program counter (registered)
//  sp         out  $clog2(DEPTH+1)       stack occupancy, 0..DEPTH
//  stk_empty  out  1                     sp == 0
//  stk_full   out  1                     sp == DEPTH
//  ovf_err    out  1                     sticky: jsr attempted while full
//  udf_err    out  1                     sticky: ret attempted while empty
// BEHAVIOUR
//  Reset (async assert, sync to clk on release): pc=RESET_PC, sp=0, stk_empty=1, stk_full=0,
//   ovf_err=0, udf_err=0. Stack contents are don't-care and never observable.
//  Each rising edge with en=1 performs exactly one operation, by priority:
//   load > jsr > ret > increment. Lower-priority strobes in the same cycle are ignored (no push/pop).
//   load: pc <= addr. Stack untouched.
//   jsr, sp<DEPTH: stack[sp] <= pc+1; sp <= sp+1; pc <= pc + sext(addr[OFFSET_W-1:0]).
//   jsr, sp==DEPTH: no push, pc and sp hold, ovf_err <= 1.
//   ret, sp>0: pc <= stack[sp-1]; sp <= sp-1.
//   ret, sp==0: pc and sp hold, udf_err <= 1.
//   none: pc <= pc+1.
//  en=0: pc, sp, stack and error flags hold (err_clr still acts).
//  Latency: every result is visible on pc one edge after the strobes are sampled; no bubbles,
//   back-to-back jsr/ret on consecutive cycles are legal (LIFO order preserved).
//  Arithmetic: pc+1 and pc+offset are modulo 2^ADDR_W (wrap, no flag). Pushed return is
//   (pc+1) mod 2^ADDR_W.
//  Errors: sticky until rst or err_clr. err_clr and a new error in the same cycle: error wins (flag=1).
//  stk_empty/stk_full are decoded from the registered sp (combinational, glitch-free relative to sp).
//  Reset asserted mid-operation: all outputs return to reset values immediately, regardless of clk.
// TESTING
//  T1 reset, en=1 for 5 cycles -> pc 0,1,2,3,4,5; sp=0; stk_empty=1.
//  T2 pc=0x010, jsr addr=0x020 -> pc=0x030, sp=1; ret next cycle -> pc=0x011, sp=0.
//  T3 pc=0x100, jsr offset=10'h3F0 (-16) -> pc=0x0F0; pc=0x7FF, increment -> pc=0x000.
//  T4 DEPTH=4: 4 nested jsr -> stk_full=1; 5th jsr -> pc unchanged, ovf_err=1; 4 ret unwind
//     in exact reverse order; 5th ret -> pc holds, udf_err=1; err_clr -> both flags 0.
//  T5 load+jsr+ret same cycle, addr=0x2AA -> pc=0x2AA, sp unchanged; en=0 with jsr -> no change.
//  T6 rst pulsed between clk edges after 2 pushes -> pc=RESET_PC, sp=0 without waiting for clk.

Source files
------------

// File: rtl/pc_stack_if.sv
// Fetch-side bus for pc_stack: step strobes from the sequencer, PC and stack status back.
// The master drives the strobes and the slave (pc_stack) drives the status.
interface pc_stack_if #(
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 4
);
  localparam int SP_W = $clog2(DEPTH + 1);

  logic              en;
  logic              load;
  logic              jsr;
  logic              ret;
  logic [ADDR_W-1:0] addr;
  logic              err_clr;
  logic [ADDR_W-1:0] pc;
  logic [SP_W-1:0]   sp;
  logic              stk_empty;
  logic              stk_full;
  logic              ovf_err;
  logic              udf_err;

  modport master (
    output en, load, jsr, ret, addr, err_clr,
    input  pc, sp, stk_empty, stk_full, ovf_err, udf_err
  );

  modport slave (
    input  en, load, jsr, ret, addr, err_clr,
    output pc, sp, stk_empty, stk_full, ovf_err, udf_err
  );
endinterface

// File: rtl/pc_stack.sv
// Program counter with a return-address stack, used for nested calls in the fetch stage.
// Overflow and underflow leave the PC and stack untouched and raise sticky error flags.
module pc_stack #(
  parameter int                ADDR_W   = 11,
  parameter int                OFFSET_W = 10,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic       clk,
  input logic       rst,
  pc_stack_if.slave bus
);
  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0] r_pc;
  logic [SP_W-1:0]   r_sp;
  logic              r_ovf;
  logic              r_udf;
  logic [ADDR_W-1:0] r_stack [DEPTH];

  logic [ADDR_W-1:0] w_pc_next;
  logic [SP_W-1:0]   w_sp_next;
  logic              w_ovf_next;
  logic              w_udf_next;
  logic              w_ovf_set;
  logic              w_udf_set;
  logic              w_push;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_offset;
  logic [ADDR_W-1:0] w_pc_rel;
  logic [ADDR_W-1:0] w_top;
  logic [IDX_W-1:0]  w_push_idx;
  logic [IDX_W-1:0]  w_pop_idx;
  logic              w_empty;
  logic              w_full;

  assign w_empty    = (r_sp == '0);
  assign w_full     = (r_sp == SP_W'(DEPTH));
  assign w_pc_inc   = r_pc + ADDR_W'(1);
  assign w_offset   = ADDR_W'(signed'(bus.addr[OFFSET_W-1:0]));
  assign w_pc_rel   = r_pc + w_offset;
  assign w_push_idx = IDX_W'(r_sp);
  assign w_pop_idx  = IDX_W'(r_sp - SP_W'(1));
  // Read of an empty stack yields stale data, but the pop is suppressed then.
  assign w_top      = r_stack[w_pop_idx];

  always_comb begin
    w_pc_next = r_pc;
    w_sp_next = r_sp;
    w_push    = 1'b0;
    w_ovf_set = 1'b0;
    w_udf_set = 1'b0;
    if (bus.en) begin
      if (bus.load) begin
        w_pc_next = bus.addr;
      end else if (bus.jsr) begin
        if (!w_full) begin
          w_push    = 1'b1;
          w_sp_next = r_sp + SP_W'(1);
          w_pc_next = w_pc_rel;
        end else begin
          w_ovf_set = 1'b1;
        end
      end else if (bus.ret) begin
        if (!w_empty) begin
          w_sp_next = r_sp - SP_W'(1);
          w_pc_next = w_top;
        end else begin
          w_udf_set = 1'b1;
        end
      end else begin
        w_pc_next = w_pc_inc;
      end
    end
    // A fresh error outranks a simultaneous clear.
    w_ovf_next = w_ovf_set | (r_ovf & ~bus.err_clr);
    w_udf_next = w_udf_set | (r_udf & ~bus.err_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc  <= RESET_PC;
      r_sp  <= '0;
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_pc  <= w_pc_next;
      r_sp  <= w_sp_next;
      r_ovf <= w_ovf_next;
      r_udf <= w_udf_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_stack[w_push_idx] <= w_pc_inc;
    end
  end

  assign bus.pc        = r_pc;
  assign bus.sp        = r_sp;
  assign bus.stk_empty = w_empty;
  assign bus.stk_full  = w_full;
  assign bus.ovf_err   = r_ovf;
  assign bus.udf_err   = r_udf;
endmodule

// File: tb/tb_pc_stack.sv
// Bench for pc_stack: directed scenarios with literal expectations, then random strobes
// compared every cycle against a queue-based model of the call stack.
module tb_pc_stack;
  localparam int ADDR_W   = 11;
  localparam int OFFSET_W = 10;
  localparam int DEPTH    = 4;
  localparam int AMOD     = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  pc_stack_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) ifc ();

  pc_stack #(
    .ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W), .DEPTH(DEPTH), .RESET_PC(11'h000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc.slave)
  );

  always #5 clk = ~clk;

  // Reference model: plain integers and a LIFO queue.
  int m_pc  = 0;
  int m_ovf = 0;
  int m_udf = 0;
  int m_stk[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc  = 0;
      m_ovf = 0;
      m_udf = 0;
      m_stk.delete();
    end else begin
      int ovf_set;
      int udf_set;
      int off;
      logic [OFFSET_W-1:0] o;
      ovf_set = 0;
      udf_set = 0;
      if (ifc.en) begin
        if (ifc.load) begin
          m_pc = int'(ifc.addr);
        end else if (ifc.jsr) begin
          if (m_stk.size() < DEPTH) begin
            o   = ifc.addr[OFFSET_W-1:0];
            off = int'(o);
            if (o[OFFSET_W-1]) off = off - (1 << OFFSET_W);
            m_stk.push_back((m_pc + 1) % AMOD);
            m_pc = ((m_pc + off) % AMOD + AMOD) % AMOD;
          end else begin
            ovf_set = 1;
          end
        end else if (ifc.ret) begin
          if (m_stk.size() > 0) m_pc = m_stk.pop_back();
          else udf_set = 1;
        end else begin
          m_pc = (m_pc + 1) % AMOD;
        end
      end
      if (ifc.err_clr) begin
        m_ovf = 0;
        m_udf = 0;
      end
      if (ovf_set) m_ovf = 1;
      if (udf_set) m_udf = 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("cyc_pc",    int'(ifc.pc),        m_pc);
      chk("cyc_sp",    int'(ifc.sp),        m_stk.size());
      chk("cyc_empty", int'(ifc.stk_empty), int'(m_stk.size() == 0));
      chk("cyc_full",  int'(ifc.stk_full),  int'(m_stk.size() == DEPTH));
      chk("cyc_ovf",   int'(ifc.ovf_err),   m_ovf);
      chk("cyc_udf",   int'(ifc.udf_err),   m_udf);
    end
  end

  task automatic step(input logic e, input logic l, input logic j, input logic r,
                      input logic [ADDR_W-1:0] a, input logic c);
    ifc.en      = e;
    ifc.load    = l;
    ifc.jsr     = j;
    ifc.ret     = r;
    ifc.addr    = a;
    ifc.err_clr = c;
    @(posedge clk);
    #1;
    $display("step en=%0b ld=%0b jsr=%0b ret=%0b addr=%03h clr=%0b -> pc=%03h sp=%0d ovf=%0b udf=%0b",
             e, l, j, r, a, c, ifc.pc, ifc.sp, ifc.ovf_err, ifc.udf_err);
  endtask

  initial begin
    ifc.en = 1'b0; ifc.load = 1'b0; ifc.jsr = 1'b0; ifc.ret = 1'b0;
    ifc.addr = '0; ifc.err_clr = 1'b0;
    rst = 1'b1;
    #2;
    chk("rst_pc",    int'(ifc.pc), 0);
    chk("rst_sp",    int'(ifc.sp), 0);
    chk("rst_empty", int'(ifc.stk_empty), 1);
    chk("rst_full",  int'(ifc.stk_full), 0);
    chk("rst_flags", int'({ifc.ovf_err, ifc.udf_err}), 0);
    #10 rst = 1'b0;

    // T1: sequential increment
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, '0, 0);
    chk("t1_pc", int'(ifc.pc), 5);
    chk("t1_empty", int'(ifc.stk_empty), 1);

    // T2: call and return
    step(1, 1, 0, 0, 11'h010, 0);
    step(1, 0, 1, 0, 11'h020, 0);
    chk("t2_call_pc", int'(ifc.pc), 'h030);
    chk("t2_call_sp", int'(ifc.sp), 1);
    step(1, 0, 0, 1, '0, 0);
    chk("t2_ret_pc", int'(ifc.pc), 'h011);
    chk("t2_ret_sp", int'(ifc.sp), 0);

    // T3: negative offset and PC wrap
    step(1, 1, 0, 0, 11'h100, 0);
    step(1, 0, 1, 0, 11'h3F0, 0);
    chk("t3_neg_pc", int'(ifc.pc), 'h0F0);
    step(1, 0, 0, 1, '0, 0);
    chk("t3_ret_pc", int'(ifc.pc), 'h101);
    step(1, 1, 0, 0, 11'h7FF, 0);
    step(1, 0, 0, 0, '0, 0);
    chk("t3_wrap_pc", int'(ifc.pc), 0);

    // T4: fill, overflow, unwind, underflow, clear
    for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 11'h005, 0);
    chk("t4_full", int'(ifc.stk_full), 1);
    chk("t4_pc4", int'(ifc.pc), 20);
    step(1, 0, 1, 0, 11'h005, 0);
    chk("t4_ovf_pc", int'(ifc.pc), 20);
    chk("t4_ovf", int'(ifc.ovf_err), 1);
    step(1, 0, 0, 1, '0, 0); chk("t4_ret1", int'(ifc.pc), 16);
    step(1, 0, 0, 1, '0, 0); chk("t4_ret2", int'(ifc.pc), 11);
    step(1, 0, 0, 1, '0, 0); chk("t4_ret3", int'(ifc.pc), 6);
    step(1, 0, 0, 1, '0, 0); chk("t4_ret4", int'(ifc.pc), 1);
    step(1, 0, 0, 1, '0, 0);
    chk("t4_udf_pc", int'(ifc.pc), 1);
    chk("t4_udf", int'(ifc.udf_err), 1);
    step(1, 0, 0, 1, '0, 1);
    chk("t4_clr_vs_err", int'({ifc.ovf_err, ifc.udf_err}), 1);
    step(0, 0, 0, 0, '0, 1);
    chk("t4_clr", int'({ifc.ovf_err, ifc.udf_err}), 0);

    // T5: priority and enable gating
    step(1, 1, 0, 0, 11'h050, 0);
    step(1, 0, 1, 0, 11'h010, 0);
    step(1, 1, 1, 1, 11'h2AA, 0);
    chk("t5_prio_pc", int'(ifc.pc), 'h2AA);
    chk("t5_prio_sp", int'(ifc.sp), 1);
    step(0, 0, 1, 0, 11'h010, 0);
    chk("t5_en0_pc", int'(ifc.pc), 'h2AA);
    chk("t5_en0_sp", int'(ifc.sp), 1);
    step(1, 0, 0, 1, '0, 0);
    chk("t5_ret_pc", int'(ifc.pc), 'h051);

    // T6: asynchronous reset between edges
    step(1, 0, 1, 0, 11'h040, 0);
    step(1, 0, 1, 0, 11'h040, 0);
    #2 rst = 1'b1;
    #1;
    chk("t6_pc", int'(ifc.pc), 0);
    chk("t6_sp", int'(ifc.sp), 0);
    chk("t6_empty", int'(ifc.stk_empty), 1);
    #2 rst = 1'b0;

    // Random strobes against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 9) != 0),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 2) == 0),
           ADDR_W'($urandom),
           ($urandom_range(0, 19) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
